// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_t        : loader FSM encoding
//   BYTES_PER_WORD : host bytes per instruction word
//   LEN_W          : width of the frame length field (word count)
//   WORD_W         : instruction word width
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Assembles little-endian 32-bit words from a byte stream.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : drop any partial word and restart at byte 0
//   accept          : byte_in is consumed this cycle
//   byte_in         : incoming byte
//   word_c          : full word formed by the bytes so far plus byte_in
//   word_complete_c : high in the cycle the 4th byte of a word is accepted
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_complete_c
);

  // Only the first three bytes need storing; the fourth arrives on byte_in.
  logic [WORD_W-9:0] shift_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else if (accept) begin
      shift_q <= {byte_in, shift_q[WORD_W-9:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_c          = {byte_in, shift_q};
  assign word_complete_c = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte frame from the
// host and writes the assembled words sequentially into instruction memory
// while holding the core in reset.
//   clk, rst             : clock, synchronous active-high reset
//   start                : begins a load when idle
//   byte_valid/byte_data : host byte stream, byte_ready is the handshake
//   wr_en/wr_addr/wr_data: instruction memory write port (word addressed)
//   core_hold            : core reset while loading
//   done                 : one-cycle end-of-load pulse
//   err                  : sticky overflow (or checksum) error
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte covering every prior frame byte.
module imem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              err
);
  import imem_loader_pkg::*;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t TAIL_STATE = CHK;
`else
  localparam state_t TAIL_STATE = DONE;
`endif

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  widx;
  logic              accept_c;
  logic              asm_clear_c;
  logic [WORD_W-1:0] word_c;
  logic              word_complete_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept_c    = byte_valid && byte_ready;
  assign asm_clear_c = (state == IDLE) && start;

  word_assembler u_asm (
    .clk             (clk),
    .rst             (rst),
    .clear           (asm_clear_c),
    .accept          (accept_c && (state == DATA)),
    .byte_in         (byte_data),
    .word_c          (word_c),
    .word_complete_c (word_complete_c)
  );

  // Loader FSM; byte_ready/done are set alongside the transition so they
  // track the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      widx       <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_hold  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept_c && (state != CHK)) csum <= csum ^ byte_data;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LEN_LO;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            err        <= 1'b0;
            widx       <= '0;
            len        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
          end
        end
        LEN_LO: begin
          if (accept_c) begin
            len[7:0] <= byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept_c) begin
            len[15:8] <= byte_data;
            if ({byte_data, len[7:0]} == '0) begin
              state      <= TAIL_STATE;
              byte_ready <= (TAIL_STATE == CHK);
              done       <= (TAIL_STATE == DONE);
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_complete_c) begin
            // Words past the end of memory are consumed but dropped.
            if (widx < LEN_W'(DEPTH)) begin
              wr_en   <= 1'b1;
              wr_addr <= ADDR_W'(widx);
              wr_data <= word_c;
            end else begin
              err <= 1'b1;
            end
            widx <= widx + LEN_W'(1);
            if (widx == len - LEN_W'(1)) begin
              state      <= TAIL_STATE;
              byte_ready <= (TAIL_STATE == CHK);
              done       <= (TAIL_STATE == DONE);
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept_c) begin
            if (byte_data != csum) err <= 1'b1;
            state      <= DONE;
            byte_ready <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        DONE: begin
          state     <= IDLE;
          core_hold <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          core_hold  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_hold;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write/done monitor, sampled mid-cycle.
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                done_cnt = 0;
  int                hold_bad = 0;
  logic              err_at_done = 1'b0;
  logic              prev_done = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      err_at_done = err;
      if (!core_hold) hold_bad++;
    end
    if (prev_done && core_hold) hold_bad++;
    prev_done = done;
  end

  logic [7:0] frame_q[$];

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt    = 0;
    hold_bad    = 0;
    err_at_done = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns at the negedge after it is accepted.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int guard = 0;
    if (throttle) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) begin
      n_checks++;
      $display("FAIL byte_ready_timeout got 0 want 1 for byte %02h", b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Sends frame_q, followed by its XOR checksum when that feature is built.
  task automatic send_frame(input bit throttle, input bit auto_csum);
    logic [7:0] x = 8'h00;
    foreach (frame_q[i]) begin
      x ^= frame_q[i];
      send_byte(frame_q[i], throttle);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (auto_csum) send_byte(x, throttle);
`else
    if (auto_csum && x == 8'hff) byte_valid = 1'b0;
`endif
  endtask

  task automatic load_basic_frame();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (byte_ready !== 1'b0) $display("FAIL reset_byte_ready got %0b want 0", byte_ready); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== 5'd0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got %08h want 00000000", wr_data); else n_pass++;
    n_checks++; if (core_hold !== 1'b0) $display("FAIL reset_core_hold got %0b want 0", core_hold); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_basic(input bit throttle, input string tag);
    clear_mon();
    n_checks++; if (byte_ready !== 1'b0) $display("FAIL %s_idle_ready got %0b want 0", tag, byte_ready); else n_pass++;
    do_start();
    n_checks++; if (core_hold !== 1'b1) $display("FAIL %s_hold_after_start got %0b want 1", tag, core_hold); else n_pass++;
    n_checks++; if (byte_ready !== 1'b1) $display("FAIL %s_ready_after_start got %0b want 1", tag, byte_ready); else n_pass++;
    load_basic_frame();
    send_frame(throttle, 1'b1);
    n_checks++; if (done !== 1'b1) $display("FAIL %s_done_latency got %0b want 1", tag, done); else n_pass++;
    @(negedge clk);
    n_checks++; if (core_hold !== 1'b0) $display("FAIL %s_hold_released got %0b want 0", tag, core_hold); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (wa_q.size() !== 2) $display("FAIL %s_write_count got %0d want 2", tag, wa_q.size()); else n_pass++;
    if (wa_q.size() == 2) begin
      n_checks++; if (wa_q[0] !== 5'd0 || wd_q[0] !== 32'h00500113) $display("FAIL %s_word0 got %0d:%08h want 0:00500113", tag, wa_q[0], wd_q[0]); else n_pass++;
      n_checks++; if (wa_q[1] !== 5'd1 || wd_q[1] !== 32'h00210233) $display("FAIL %s_word1 got %0d:%08h want 1:00210233", tag, wa_q[1], wd_q[1]); else n_pass++;
    end
    n_checks++; if (done_cnt !== 1) $display("FAIL %s_done_count got %0d want 1", tag, done_cnt); else n_pass++;
    n_checks++; if (hold_bad !== 0) $display("FAIL %s_hold_timing got %0d want 0 violations", tag, hold_bad); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL %s_err got %0b want 0", tag, err); else n_pass++;
  endtask

  task automatic test_zero_len();
    clear_mon();
    do_start();
    frame_q = '{8'h00, 8'h00};
    send_frame(1'b0, 1'b1);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done got %0b want 1", done); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (wa_q.size() !== 0) $display("FAIL zero_writes got %0d want 0", wa_q.size()); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL zero_done_count got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL zero_err got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_overflow();
    int bad = 0;
    clear_mon();
    do_start();
    frame_q = '{8'h21, 8'h00};
    for (int k = 0; k < 132; k++) frame_q.push_back(8'(k));
    send_frame(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (wa_q.size() !== 32) $display("FAIL ovf_write_count got %0d want 32", wa_q.size()); else n_pass++;
    for (int i = 0; i < wa_q.size() && i < 32; i++) begin
      if (wa_q[i] !== 5'(i) || wd_q[i] !== {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL ovf_write_contents got %0d bad want 0 bad", bad); else n_pass++;
    n_checks++; if (err_at_done !== 1'b1) $display("FAIL ovf_err_at_done got %0b want 1", err_at_done); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL ovf_err_sticky got %0b want 1", err); else n_pass++;
    do_start();
    n_checks++; if (err !== 1'b0) $display("FAIL ovf_err_cleared got %0b want 0", err); else n_pass++;
    frame_q = '{8'h00, 8'h00};
    send_frame(1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    do_start();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33};
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (core_hold !== 1'b0) $display("FAIL mid_core_hold got %0b want 0", core_hold); else n_pass++;
    n_checks++; if (byte_ready !== 1'b0) $display("FAIL mid_byte_ready got %0b want 0", byte_ready); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL mid_err got %0b want 0", err); else n_pass++;
    byte_valid = 1'b1;
    byte_data  = 8'h5a;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    n_checks++; if (wa_q.size() !== 1) $display("FAIL mid_write_count got %0d want 1", wa_q.size()); else n_pass++;
    n_checks++; if (done_cnt !== 0) $display("FAIL mid_done_count got %0d want 0", done_cnt); else n_pass++;
    test_basic(1'b0, "after_rst");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_mon();
    do_start();
    load_basic_frame();
    frame_q.push_back(8'h50);
    send_frame(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_at_done !== 1'b0) $display("FAIL csum_good_err got %0b want 0", err_at_done); else n_pass++;
    clear_mon();
    do_start();
    load_basic_frame();
    frame_q.push_back(8'h51);
    send_frame(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_at_done !== 1'b1) $display("FAIL csum_bad_err got %0b want 1", err_at_done); else n_pass++;
    n_checks++; if (wa_q.size() !== 2) $display("FAIL csum_bad_writes got %0d want 2", wa_q.size()); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "throttled");
    test_zero_len();
    test_overflow();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer end of the instruction-memory interface; fetch is the reader.
- Receives a byte stream from a host link and assembles little-endian 32-bit instruction words.
- Writes words sequentially into the instruction memory through a write port.
- Holds the core in reset (core_hold) while a program is loading.

Parameters:
- DEPTH, 32, instruction memory depth in words.
- ADDR_W, 5, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; begins a load when in IDLE
- byte_valid  in  1  host byte present
- byte_data  in  8  host byte
- byte_ready  out  1  loader can accept a byte
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  ADDR_W  word index (not byte address)
- wr_data  out  32  instruction word
- core_hold  out  1  high while loading; drives the core reset
- done  out  1  one-cycle pulse at end of load
- err  out  1  sticky error flag

Behaviour:
- Reset: state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=0, done=0, err=0. Byte and word counters are cleared.
- A byte is accepted only in a cycle where byte_valid && byte_ready.
- byte_ready=1 in LEN_LO, LEN_HI, DATA and CHK states; 0 in IDLE and DONE.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes. Each word is little-endian: first byte goes to [7:0], fourth byte to [31:24].
- IDLE: start=1 clears err and the word index, then goes to LEN_LO. core_hold=1 from the next cycle.
- LEN_LO -> LEN_HI on an accepted byte.
- LEN_HI -> DATA on an accepted byte. If N==0, go to DONE instead (or CHK when enabled).
- DATA: a 2-bit byte counter shifts bytes into the assembly register. On acceptance of the 4th byte:
  - Next cycle: wr_en=1 for exactly one cycle, with wr_addr = word index and wr_data = assembled word. Latency is 1 cycle.
  - Word index then increments.
  - After word N-1, go to DONE (or CHK).
- Overflow: words with index >= DEPTH are consumed but not written (wr_en stays 0), and err is set. wr_addr never wraps.
- DONE: lasts exactly 1 cycle with done=1 and core_hold=1, then returns to IDLE with core_hold=0.
- start outside IDLE is ignored.
- An idle host (byte_valid=0) stalls indefinitely with no timeout.
- rst mid-load aborts to IDLE: no further writes, core_hold=0, err=0. Words already written remain in memory.
- err persists until the next accepted start or rst.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or after LEN_HI when N==0), state CHK accepts one byte.
  - The expected value is the XOR of all prior frame bytes, length bytes included.
  - A mismatch sets err.
  - Writes already performed are not undone.
  - CHK -> DONE on acceptance.
- Undefined: no CHK state and no XOR register; DATA/LEN_HI go directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE) as a typedef;
  - the byte-per-word constant 4;
  - the length-field width constant 16.
- One sub-module, word_assembler:
  - byte shift register plus 2-bit counter;
  - inputs: clk, rst, clear, byte accept, byte;
  - outputs: word, word_complete pulse.
- The top FSM owns the counters, the write port and err.

Test Plan:
- Basic load: rst, start, then bytes 02 00 13 01 50 00 33 02 21 00 with byte_valid held high.
  - Required: two wr_en pulses: addr0=0x00500113, then addr1=0x00210233.
  - done pulses once; core_hold falls the cycle after done; err=0.
- Throttled host: same frame, byte_valid toggling 1/0 every cycle.
  - Required: identical writes; no byte is lost or duplicated; byte_ready=0 in IDLE.
- Zero length: start, bytes 00 00.
  - Required: no wr_en; done the next cycle (with the checksum macro, after checksum byte 00); err=0.
- Overflow: DEPTH=32, N=33 (bytes 21 00), 132 data bytes.
  - Required: 32 writes at addr 0..31; word 33 is not written; err=1 at done; a new start clears err.
- Reset mid-load: rst asserted after 5 data bytes.
  - Required: state IDLE, core_hold=0, no further wr_en, byte_ready=0.
  - A following full load writes from addr0.
- Checksum (IMEM_LOADER_CHECKSUM_EN): basic frame plus byte 0x50 -> err=0. Same frame plus 0x51 -> err=1; both words were still written.
